// File: rtl/lab01_pkg.sv
// Shared definitions for the AND-gate exerciser: FSM state encoding and
// the default per-vector settle time.
package lab01_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 2;
    localparam int TIMER_W               = 8;

endpackage

// File: rtl/andgate2_exerciser_if.sv
// Signal bundle between the exerciser (master) and the gate under test plus
// whoever starts runs and reads results (slave).
//
// Handshake: start is a level, sampled on every rising edge. It is acted on
// only when the exerciser is idle or done (busy low). busy and done are
// registered and mutually exclusive. Results are valid whenever done is high.
interface andgate2_exerciser_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            resp;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;

    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/andgate2_exerciser_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each vector is held.
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/andgate2_exerciser.sv
// Walks every input vector of an N-input AND gate, holds each for a settle
// time, and scores the gate response against the expected AND.
module andgate2_exerciser
    import lab01_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    andgate2_exerciser_if.master bus,
    output state_t              dbg_state_o
);
    localparam logic [N_IN-1:0]    LAST_VEC    = '1;
    localparam logic [N_IN-1:0]    STIM_ONE    = N_IN'(1);
    localparam logic [N_IN:0]      ERR_ONE     = (N_IN + 1)'(1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmr_load, tmr_dec, tmr_zero;

    settle_timer #(.W(TIMER_W)) u_settle_timer (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        err_d    = err_q;
        ff_d     = ff_q;
        busy_d   = busy_q;
        done_d   = done_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    stim_d   = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) state_d = CHECK;
                else          tmr_dec = 1'b1;
            end
            CHECK: begin
                // Only the first mismatch of a run records its vector.
                if (bus.resp != (&stim_q)) begin
                    err_d = err_q + ERR_ONE;
                    if (err_q == '0) ff_d = stim_q;
                end
                if (stim_q == LAST_VEC) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    stim_d   = stim_q + STIM_ONE;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
    assign bus.pass       = done_q && (err_q == '0);
    assign dbg_state_o    = state_q;
endmodule

// File: doc/andgate2_exerciser.md
# andgate2_exerciser

Self-checking stimulus/response sequencer that sits directly upstream of the 2-input AND gate and drives its inputs. It also consumes the gate's output. On a start pulse it walks every input combination in ascending binary order, waits a programmable settle time per vector, and compares the gate output against the expected AND of the inputs. It reports mismatch count, first failing vector and a pass flag. This lets the lab's AND gate be checked in hardware (switches/LEDs) as well as in simulation.

## Interface
- N_IN, default 2: number of gate inputs; vector width; 2^N_IN vectors per run.
- SETTLE_CYCLES, default 2: clock cycles each vector is held before checking; legal range 1..255.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled each edge; high in IDLE or DONE begins a run.
- stim  out  N_IN  drive to gate inputs (bit 1 = a, bit 0 = b for N_IN=2).
- resp  in  1  gate output (y).
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors in the last run.
- first_fail  out  N_IN  index of first mismatching vector; 0 when err_count==0.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset (async, immediate): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, settle counter=0.
- IDLE: on edge with start=1, the block sets stim<=0, err_count<=0, first_fail<=0, cnt<=SETTLE_CYCLES-1, busy<=1 and enters SETTLE.
- SETTLE: if cnt==0, go to CHECK; otherwise cnt<=cnt-1. stim is held stable.
- CHECK: compare resp against expected = &stim. On mismatch, err_count<=err_count+1; if err_count was 0, first_fail<=stim. If stim is all ones (last vector), go to DONE with busy<=0, done<=1. Otherwise stim<=stim+1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- DONE: outputs are held; stim keeps the last vector. start=1 clears done/pass and restarts exactly as from IDLE.
- start during SETTLE/CHECK is ignored; the run is not restarted.
- err_count never wraps: its width holds the maximum 2^N_IN.
- stim increments in unsigned binary; the last-vector test is the all-ones compare, with no wrap to 0.

## Timing
- Per vector: SETTLE_CYCLES cycles in SETTLE plus 1 in CHECK.
- Run length: 2^N_IN*(SETTLE_CYCLES+1) cycles from the start-sampling edge to the edge that sets done. Defaults give 12 cycles.
- resp is sampled at the CHECK-exit edge, SETTLE_CYCLES+1 edges after stim changed. The gate path must settle within SETTLE_CYCLES clock periods.
- busy and done are registered, and are never both high.
- pass is combinational from the registered done and err_count.
- Reset mid-run aborts immediately. No partial results are retained. The next start runs the full sequence.

## Structure
- Shared package lab01_pkg holds the state encoding constants (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3) and the default SETTLE_CYCLES value.
- One sub-module is natural: settle_timer, a loadable down-counter with zero flag. The FSM, vector counter and scoreboard stay in the top module.

## Test plan
- Correct AND gate as the device under test, defaults, start pulse at cycle 0. Required: done rises 12 edges later; err_count=0, first_fail=0, pass=1; stim visits 00,01,10,11 with each held 3 cycles.
- OR gate substituted. Required: mismatches at 01 and 10; err_count=2, first_fail=1, pass=0.
- resp stuck at 0. Required: err_count=1, first_fail=3, pass=0.
- Assert reset_n low at cycle 5 of a run. Required: all outputs 0 in the same cycle (async), state IDLE. A fresh start then yields a full 12-cycle run with correct results.
- Hold start high throughout a run. Required: no restart while busy. Run completes at 12 cycles, then restarts from DONE on the next edge: done drops and stim=00.
- SETTLE_CYCLES=1. Required: each vector held 2 cycles; done 8 edges after start; correct AND gives pass=1.
